// File: rtl/lfsr_arb_pkg.sv
// Shared types and default sizing for the LFSR stream arbiter.
package lfsr_arb_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_BURST_LEN  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/lfsr_stream_arbiter_rr_picker.sv
// Round-robin picker: first set request at or after the pointer, wrapping.
// Purely combinational; o_valid flags that any request was found.
module rr_picker
    import lfsr_arb_pkg::*;
#(
    parameter int  NUM_REQ = DEF_NUM_REQ,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_rr_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_idx,
    output logic               o_valid
);

    int w_pos;

    // Scan from the pointer upward, wrapping, and keep the first hit.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_pos   = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            w_pos = int'(i_rr_ptr) + off;
            if (w_pos >= NUM_REQ) begin
                w_pos = w_pos - NUM_REQ;
            end
            if (!o_valid && i_req[w_pos]) begin
                o_valid        = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_idx          = PTR_W'(w_pos);
            end
        end
    end

endmodule

// File: rtl/lfsr_stream_arbiter.sv
// Distributes an LFSR word stream to NUM_REQ consumers in fixed-length
// bursts, round-robin. Data path is combinational; only ownership and the
// beat counter are registered.
// Optional per-port delivered-beat statistics: define LFSR_ARB_STATS_EN.
//
//   state | meaning
//   IDLE  | no owner, source stalled, picking next grant
//   BURST | grant held, beats routed to owner until BURST_LEN delivered
module lfsr_stream_arbiter
    import lfsr_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int BURST_LEN  = DEF_BURST_LEN
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [DATA_WIDTH-1:0]         in_tdata,
    input  logic                          in_tvalid,
    output logic                          in_tready,
    input  logic [NUM_REQ-1:0]            req,
    output logic [NUM_REQ*DATA_WIDTH-1:0] out_tdata,
    output logic [NUM_REQ-1:0]            out_tvalid,
    input  logic [NUM_REQ-1:0]            out_tready,
    output logic [NUM_REQ-1:0]            out_tlast,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ*16-1:0]         beat_count
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BURST_LEN) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(NUM_REQ - 1);

    arb_state_t         r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [PTR_W-1:0]   r_gidx;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [CNT_W-1:0]   r_cnt;

    logic [NUM_REQ-1:0] w_pick_grant;
    logic [PTR_W-1:0]   w_pick_idx;
    logic               w_pick_valid;
    logic               w_in_burst;
    logic               w_hs;
    logic               w_last;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_picker (
        .i_req    (req),
        .i_rr_ptr (r_rr_ptr),
        .o_grant  (w_pick_grant),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_valid)
    );

    assign w_in_burst = (r_state == BURST);
    assign in_tready  = w_in_burst && out_tready[r_gidx];
    assign w_hs       = in_tready && in_tvalid;
    assign w_last     = w_in_burst && (r_cnt == CNT_LAST);
    assign grant      = r_grant;

    // Route the source to the current owner; every other port stays quiet.
    always_comb begin
        out_tvalid = '0;
        out_tdata  = '0;
        out_tlast  = '0;
        if (w_in_burst) begin
            out_tvalid[r_gidx]                          = in_tvalid;
            out_tdata[r_gidx*DATA_WIDTH +: DATA_WIDTH] = in_tdata;
            out_tlast[r_gidx]                           = w_last;
        end
    end

    // Ownership FSM: pick in IDLE, count beats in BURST, advance pointer on tlast.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_gidx   <= '0;
            r_rr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_grant <= w_pick_grant;
                        r_gidx  <= w_pick_idx;
                        r_cnt   <= '0;
                        r_state <= BURST;
                    end
                end
                BURST: begin
                    if (w_hs) begin
                        if (w_last) begin
                            r_state  <= IDLE;
                            r_grant  <= '0;
                            r_cnt    <= '0;
                            r_rr_ptr <= (r_gidx == PTR_MAX) ? '0 : r_gidx + PTR_W'(1);
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef LFSR_ARB_STATS_EN
    logic [15:0] r_beat_cnt [NUM_REQ];

    // Saturating count of beats actually handed to each port.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_beat_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_hs && (r_gidx == PTR_W'(i)) && (r_beat_cnt[i] != 16'hFFFF)) begin
                    r_beat_cnt[i] <= r_beat_cnt[i] + 16'd1;
                end
            end
        end
    end

    // Flatten the counters onto the output bus.
    always_comb begin
        beat_count = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            beat_count[i*16 +: 16] = r_beat_cnt[i];
        end
    end
`else
    assign beat_count = '0;
`endif

endmodule

// File: tb/tb_lfsr_stream_arbiter.sv
// Scoreboard bench for lfsr_stream_arbiter (4 ports, 8-bit data, 4-beat bursts).
// Source words are sequential so every accepted beat carries a known value.
module tb_lfsr_stream_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int BL = 4;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic [DW-1:0]  in_tdata = 8'h10;
    logic           in_tvalid = 1'b0;
    logic           in_tready;
    logic [NR-1:0]  req = '0;
    logic [NR*DW-1:0] out_tdata;
    logic [NR-1:0]  out_tvalid;
    logic [NR-1:0]  out_tready = '1;
    logic [NR-1:0]  out_tlast;
    logic [NR-1:0]  grant;
    logic [NR*16-1:0] beat_count;

    lfsr_stream_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .BURST_LEN  (BL)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_tdata   (in_tdata),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
        .req        (req),
        .out_tdata  (out_tdata),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .out_tlast  (out_tlast),
        .grant      (grant),
        .beat_count (beat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           port;
        logic [DW-1:0] data;
        logic         last;
    } beat_t;

    beat_t         beat_q[$];
    logic [NR-1:0] grant_q[$];
    int            total = 0;
    int            bad = 0;
    logic [NR-1:0] prev_g = '0;
    logic          pend;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_beats(input int port, input logic [DW-1:0] first, input int n);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.port = port;
            b.data = first + DW'(k);
            b.last = (k == BL - 1);
            beat_q.push_back(b);
        end
    endtask

    task automatic wait_grants(input string name, input int n, input int budget);
        int cnt;
        logic [NR-1:0] pg;
        cnt = 0;
        pg  = grant;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (grant != '0 && pg == '0) cnt++;
            pg = grant;
            if (cnt == n) break;
        end
        chk(name, 64'(cnt), 64'(n));
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (grant == '0) break;
        end
        chk(name, 64'(grant), 64'd0);
    endtask

    task automatic pulse_reset();
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    // Source: advance the word only after a beat was accepted.
    initial begin
        forever begin
            @(negedge clk);
            pend = resetn && in_tvalid && in_tready;
            @(posedge clk); #1;
            if (pend) in_tdata = in_tdata + 8'd1;
        end
    end

    // Monitor: routing sanity each cycle, grant order and beat contents on events.
    always @(negedge clk) begin
        beat_t b;
        chk("stray_tvalid", 64'(out_tvalid & ~grant), 64'd0);
        chk("stray_tlast", 64'(out_tlast & ~grant), 64'd0);
        if (grant == '0) chk("idle_tready", 64'(in_tready), 64'd0);
        if (grant != '0 && grant != prev_g) begin
            if (grant_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL grant_unexpected: got %0h expected none", grant);
            end else begin
                chk("grant_order", 64'(grant), 64'(grant_q.pop_front()));
            end
        end
        prev_g = grant;
        if (resetn) begin
            for (int i = 0; i < NR; i++) begin
                if (out_tvalid[i] && out_tready[i]) begin
                    if (beat_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL beat_unexpected: got port %0d data %0h expected none", i, out_tdata[i*DW +: DW]);
                    end else begin
                        b = beat_q.pop_front();
                        chk("beat_port", 64'(i), 64'(b.port));
                        chk("beat_data", 64'(out_tdata[i*DW +: DW]), 64'(b.data));
                        chk("beat_last", 64'(out_tlast[i]), 64'(b.last));
                    end
                end
            end
        end
    end

    initial begin
        logic [15:0] exp_bc [NR];

        // Reset state
        in_tvalid = 1'b1;
        @(posedge clk); #1;
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_tready", 64'(in_tready), 64'd0);
        chk("rst_tvalid", 64'(out_tvalid), 64'd0);
        chk("rst_beat_count", beat_count, 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;

        // Single requester: grant one cycle later, four beats to port 0
        grant_q.push_back(4'b0001);
        exp_beats(0, 8'h10, 4);
        req = 4'b0001;
        @(posedge clk); #1;
        chk("s1_grant_latency", 64'(grant), 64'h1);
        req = '0;
        wait_idle("s1_idle", 20);

        // All requesting from pointer 0: 0,1,2,3,0
        pulse_reset();
        grant_q.push_back(4'b0001);
        grant_q.push_back(4'b0010);
        grant_q.push_back(4'b0100);
        grant_q.push_back(4'b1000);
        grant_q.push_back(4'b0001);
        exp_beats(0, 8'h14, 4);
        exp_beats(1, 8'h18, 4);
        exp_beats(2, 8'h1C, 4);
        exp_beats(3, 8'h20, 4);
        exp_beats(0, 8'h24, 4);
        req = 4'b1111;
        wait_grants("s2_grants", 5, 200);
        req = '0;
        wait_idle("s2_idle", 20);

        // Port 2 stalled by its consumer for three cycles after two beats
        grant_q.push_back(4'b0100);
        exp_beats(2, 8'h28, 4);
        req = 4'b0100;
        wait_grants("s3_grant", 1, 20);
        req = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        out_tready = 4'b1011;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("s3_stall_tready", 64'(in_tready), 64'd0);
            chk("s3_stall_data", 64'(out_tdata[2*DW +: DW]), 64'h2A);
            chk("s3_stall_tvalid", 64'(out_tvalid[2]), 64'd1);
            chk("s3_stall_tlast", 64'(out_tlast[2]), 64'd0);
            @(posedge clk); #1;
        end
        out_tready = '1;
        wait_idle("s3_idle", 20);

        // Port 1 drops its request after one beat; burst still completes
        grant_q.push_back(4'b0010);
        exp_beats(1, 8'h2C, 4);
        req = 4'b0010;
        wait_grants("s4_grant", 1, 20);
        @(posedge clk); #1;
        req = '0;
        @(negedge clk);
        chk("s4_grant_hold", 64'(grant), 64'h2);
        wait_idle("s4_idle", 20);

        // Reset during port 0 burst after two beats: burst abandoned
        grant_q.push_back(4'b0001);
        exp_beats(0, 8'h30, 2);
        req = 4'b0001;
        wait_grants("s5_grant", 1, 20);
        req = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        pulse_reset();
        chk("s5_rst_grant", 64'(grant), 64'd0);
        chk("s5_rst_tready", 64'(in_tready), 64'd0);
        chk("s5_rst_tlast", 64'(out_tlast), 64'd0);
        grant_q.push_back(4'b0001);
        exp_beats(0, 8'h32, 4);
        req = 4'b0011;
        @(posedge clk); #1;
        chk("s5_regrant", 64'(grant), 64'h1);
        req = '0;
        wait_idle("s5_idle", 20);

        // Three back-to-back bursts to port 3
        grant_q.push_back(4'b1000);
        grant_q.push_back(4'b1000);
        grant_q.push_back(4'b1000);
        exp_beats(3, 8'h36, 4);
        exp_beats(3, 8'h3A, 4);
        exp_beats(3, 8'h3E, 4);
        req = 4'b1000;
        wait_grants("s6_grants", 3, 200);
        req = '0;
        wait_idle("s6_idle", 20);
        @(negedge clk);

`ifdef LFSR_ARB_STATS_EN
        exp_bc[0] = 16'd4;
        exp_bc[1] = 16'd0;
        exp_bc[2] = 16'd0;
        exp_bc[3] = 16'd12;
`else
        exp_bc[0] = 16'd0;
        exp_bc[1] = 16'd0;
        exp_bc[2] = 16'd0;
        exp_bc[3] = 16'd0;
`endif
        for (int i = 0; i < NR; i++) begin
            chk($sformatf("beat_count_%0d", i), 64'(beat_count[i*16 +: 16]), 64'(exp_bc[i]));
        end
        chk("beats_left", 64'(beat_q.size()), 64'd0);
        chk("grants_left", 64'(grant_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lfsr_stream_arbiter.md
LFSR_STREAM_ARBITER -- requirements
Module: lfsr_stream_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, beat width of source and sink streams.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of consumer ports (2..8).
REQ-003 SHALL have parameter BURST_LEN, default 4, beats per grant (1..256).
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port in_tdata  input  DATA_WIDTH  random word from LFSR source.
REQ-007 SHALL have port in_tvalid  input  1  source beat valid.
REQ-008 SHALL have port in_tready  output  1  source beat accepted.
REQ-009 SHALL have port req  input  NUM_REQ  per-consumer burst request, level.
REQ-010 SHALL have port out_tdata  output  NUM_REQ*DATA_WIDTH  per-consumer data, port i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port out_tvalid  output  NUM_REQ  per-consumer valid.
REQ-012 SHALL have port out_tready  input  NUM_REQ  per-consumer ready.
REQ-013 SHALL have port out_tlast  output  NUM_REQ  asserted on final beat of a burst.
REQ-014 SHALL have port grant  output  NUM_REQ  one-hot current owner, zero when idle.
REQ-015 SHALL have port beat_count  output  NUM_REQ*16  per-consumer delivered-beat counters.

Function
REQ-016 SHALL implement FSM states IDLE and BURST.
REQ-017 In IDLE with req nonzero, SHALL register a grant to the first set req at or after rr_ptr (wrapping) and enter BURST next cycle; one idle cycle minimum between bursts.
REQ-018 In BURST, grant SHALL stay constant; routing combinational: out_tvalid[g]=in_tvalid, out_tdata[g]=in_tdata, in_tready=out_tready[g]; non-granted ports: tvalid 0, tdata 0, tlast 0.
REQ-019 Beat counter (width clog2(BURST_LEN)+1) SHALL increment on each in_tvalid&&in_tready in BURST.
REQ-020 out_tlast[g] SHALL be 1 while counter==BURST_LEN-1; that beat's handshake SHALL return FSM to IDLE and set rr_ptr=(g+1) mod NUM_REQ.
REQ-021 Deassertion of req[g] mid-burst SHALL NOT end the burst; burst always delivers exactly BURST_LEN beats.
REQ-022 Stalls (in_tvalid=0 or out_tready[g]=0) SHALL hold counter and state indefinitely; no timeout.
REQ-023 in_tready SHALL be 0 in IDLE; no source beat is consumed without an owner.
REQ-024 BURST_LEN=1: tlast on every beat, each grant one beat.
REQ-025 Simultaneous requests SHALL be served round-robin; a continuously requesting port waits at most NUM_REQ-1 bursts.

Reset
REQ-026 On resetn=0 at a clock edge: state IDLE, grant 0, rr_ptr 0, beat counter 0, beat_count all 0; all out_tvalid/out_tlast and in_tready 0 from next cycle.
REQ-027 Reset mid-burst SHALL abandon the burst with no tlast issued.

Configuration
REQ-028 Macro LFSR_ARB_STATS_EN defined: beat_count[i] SHALL increment on each delivered beat to port i, saturating at 16'hFFFF.
REQ-029 Macro undefined: beat_count SHALL be constant 0 and no counter registers synthesized; port list unchanged.

Structure
REQ-030 Package lfsr_arb_pkg SHALL hold the state enum type (IDLE, BURST) and default constants for DATA_WIDTH, NUM_REQ, BURST_LEN.
REQ-031 Sub-module rr_picker SHALL compute the one-hot next grant from req and rr_ptr, purely combinational.

Verification
REQ-032 req=4'b0001, source always valid, out_tready=1 -> grant=0001 one cycle later, 4 beats to port 0 with tlast on 4th, then IDLE.
REQ-033 req=4'b1111 held -> grants in order 0001,0010,0100,1000,0001, each burst 4 beats.
REQ-034 Port 2 bursting, out_tready[2] low for 3 cycles at beat 2 -> in_tready low for those cycles, data held, still exactly 4 beats, one tlast.
REQ-035 req[1] dropped after beat 1 -> burst completes 4 beats to port 1.
REQ-036 resetn low for one cycle at beat 3 of port 0 burst -> no tlast, grant 0 next cycle, next req=4'b0011 grants port 0.
REQ-037 With LFSR_ARB_STATS_EN, 3 bursts to port 3 -> beat_count[3]=12; without macro -> 0.
